// File: rtl/mem_responder.sv
// Memory-side responder: round-robin arbitration of per-core memory requests
// onto one shared single-port synchronous RAM with a one-cycle response pulse.
module mem_responder #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CORES     = 4,
    parameter int unsigned IDX_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CORES-1:0]         request,
    input  logic [CORES-1:0]         wren,
    input  logic [CORES*WIDTH-1:0]   address,
    input  logic [CORES*WIDTH-1:0]   writedata,
    output logic [CORES-1:0]         response,
    output logic [WIDTH-1:0]         readdata,
    output logic                     busy,
    output logic [IDX_WIDTH-1:0]     grant_index,
    output logic [WIDTH-1:0]         mem_address,
    output logic [WIDTH-1:0]         mem_writedata,
    output logic                     mem_wren,
    input  logic [WIDTH-1:0]         mem_readdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_LATCH,
        S_RESPOND
    } state_e;

    state_e                 state_q;
    logic [IDX_WIDTH-1:0]   last_grant_q;
    logic [IDX_WIDTH-1:0]   grant_q;
    logic                   is_write_q;
    logic [CORES-1:0]       response_q;
    logic [WIDTH-1:0]       readdata_q;
    logic                   busy_q;
    logic [WIDTH-1:0]       mem_address_q;
    logic [WIDTH-1:0]       mem_writedata_q;
    logic                   mem_wren_q;

    logic [CORES-1:0]       req_eligible;
    logic                   pick_valid;
    logic [IDX_WIDTH-1:0]   pick_idx;
    logic [IDX_WIDTH-1:0]   cand;
    logic [WIDTH-1:0]       pick_addr;
    logic [WIDTH-1:0]       pick_data;
    logic                   pick_wren;

    // A core still sees its request high in the cycle right after its response;
    // masking it prevents serving the same access twice.
    assign req_eligible = request & ~response_q;

    // Round-robin pick: first eligible core after last_grant, modulo CORES.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 1; k <= CORES; k++) begin
            cand = IDX_WIDTH'((32'(last_grant_q) + k) % CORES);
            if (!pick_valid && req_eligible[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Operand mux for the winning core.
    always_comb begin
        pick_addr = '0;
        pick_data = '0;
        pick_wren = 1'b0;
        for (int unsigned i = 0; i < CORES; i++) begin
            if (IDX_WIDTH'(i) == pick_idx) begin
                pick_addr = address[i*WIDTH +: WIDTH];
                pick_data = writedata[i*WIDTH +: WIDTH];
                pick_wren = wren[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            last_grant_q    <= IDX_WIDTH'(CORES - 1);
            grant_q         <= '0;
            is_write_q      <= 1'b0;
            response_q      <= '0;
            readdata_q      <= '0;
            busy_q          <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
            mem_wren_q      <= 1'b0;
        end else begin
            response_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (pick_valid) begin
                        mem_address_q   <= pick_addr;
                        mem_writedata_q <= pick_data;
                        mem_wren_q      <= pick_wren;
                        is_write_q      <= pick_wren;
                        grant_q         <= pick_idx;
                        last_grant_q    <= pick_idx;
                        busy_q          <= 1'b1;
                        state_q         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mem_wren_q <= 1'b0;
                    state_q    <= S_LATCH;
                end
                S_LATCH: begin
                    if (!is_write_q) begin
                        readdata_q <= mem_readdata;
                    end
                    state_q <= S_RESPOND;
                end
                S_RESPOND: begin
                    response_q[grant_q] <= 1'b1;
                    busy_q              <= 1'b0;
                    state_q             <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign response      = response_q;
    assign readdata      = readdata_q;
    assign busy          = busy_q;
    assign grant_index   = grant_q;
    assign mem_address   = mem_address_q;
    assign mem_writedata = mem_writedata_q;
    assign mem_wren      = mem_wren_q;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: directed scenarios plus randomized traffic
// checked against a round-robin / memory reference model.
module tb_mem_responder;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned CORES     = 4;
    localparam int unsigned IDX_WIDTH = 2;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [CORES-1:0]       request = '0;
    logic [CORES-1:0]       wren = '0;
    logic [CORES*WIDTH-1:0] address = '0;
    logic [CORES*WIDTH-1:0] writedata = '0;
    logic [CORES-1:0]       response;
    logic [WIDTH-1:0]       readdata;
    logic                   busy;
    logic [IDX_WIDTH-1:0]   grant_index;
    logic [WIDTH-1:0]       mem_address;
    logic [WIDTH-1:0]       mem_writedata;
    logic                   mem_wren;
    logic [WIDTH-1:0]       mem_readdata = '0;

    int checks = 0;
    int passed = 0;

    logic [WIDTH-1:0] ram       [256];
    logic [WIDTH-1:0] model_mem [256];
    logic [WIDTH-1:0] exp_readdata;
    logic [CORES-1:0] drop_pending = '0;

    int               wr_count = 0;
    logic [WIDTH-1:0] wr_addr = '0;
    logic [WIDTH-1:0] wr_data = '0;

    always #5 clk = ~clk;

    mem_responder #(.WIDTH(WIDTH), .CORES(CORES), .IDX_WIDTH(IDX_WIDTH)) dut (
        .clk(clk), .reset(reset), .request(request), .wren(wren),
        .address(address), .writedata(writedata), .response(response),
        .readdata(readdata), .busy(busy), .grant_index(grant_index),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_wren(mem_wren), .mem_readdata(mem_readdata)
    );

    // Synchronous single-port RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_wren) ram[mem_address[7:0]] <= mem_writedata;
        mem_readdata <= ram[mem_address[7:0]];
    end

    // Records every write strobe seen on the memory bus.
    always @(posedge clk) begin
        if (mem_wren === 1'b1) begin
            wr_count <= wr_count + 1;
            wr_addr  <= mem_address;
            wr_data  <= mem_writedata;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required < 500000", $time);
        $fatal(1, "watchdog");
    end

    function automatic int rr_pick(input logic [CORES-1:0] pend, input int last);
        for (int k = 1; k <= int'(CORES); k++) begin
            if (pend[(last + k) % CORES]) return (last + k) % CORES;
        end
        return -1;
    endfunction

    task automatic set_core(input int i, input logic wr, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] d);
        request[i] = 1'b1;
        wren[i]    = wr;
        address[i*WIDTH +: WIDTH]   = a;
        writedata[i*WIDTH +: WIDTH] = d;
    endtask

    // One clock; cores drop request the cycle after they saw their response.
    task automatic step();
        @(posedge clk);
        #1;
        request      = request & ~drop_pending;
        drop_pending = response;
    endtask

    task automatic wait_resp(output logic [CORES-1:0] r, output int n);
        bit done;
        done = 0;
        r = '0;
        n = -1;
        for (int c = 1; c <= 40 && !done; c++) begin
            step();
            if (response != '0) begin
                r = response;
                n = c;
                done = 1;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        request = '0;
        wren = '0;
        drop_pending = '0;
        exp_readdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else passed++;
        checks++; if (response !== 4'b0000) $display("FAIL reset_response got=%b exp=0000", response); else passed++;
        checks++; if (mem_wren !== 1'b0) $display("FAIL reset_mem_wren got=%0b exp=0", mem_wren); else passed++;
        checks++; if (readdata !== 32'h0) $display("FAIL reset_readdata got=%h exp=0", readdata); else passed++;
        checks++; if (mem_address !== 32'h0) $display("FAIL reset_mem_address got=%h exp=0", mem_address); else passed++;
        checks++; if (grant_index !== 2'd0) $display("FAIL reset_grant_index got=%0d exp=0", grant_index); else passed++;
        do_reset();
    endtask

    task automatic test_single_read();
        ram[8'h10] = 32'hDEADBEEF;
        model_mem[8'h10] = 32'hDEADBEEF;
        set_core(0, 1'b0, 32'h10, 32'h0);
        step();
        checks++; if (mem_address !== 32'h10) $display("FAIL read_issue_addr got=%h exp=10", mem_address); else passed++;
        checks++; if (mem_wren !== 1'b0) $display("FAIL read_issue_wren got=%0b exp=0", mem_wren); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL read_busy got=%0b exp=1", busy); else passed++;
        step();
        step();
        checks++; if (response !== 4'b0000) $display("FAIL read_early_resp got=%b exp=0000", response); else passed++;
        step();
        checks++; if (response !== 4'b0001) $display("FAIL read_resp got=%b exp=0001", response); else passed++;
        checks++; if (readdata !== 32'hDEADBEEF) $display("FAIL read_data got=%h exp=deadbeef", readdata); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL read_busy_after got=%0b exp=0", busy); else passed++;
        exp_readdata = 32'hDEADBEEF;
        step();
        checks++; if (response !== 4'b0000) $display("FAIL read_resp_pulse got=%b exp=0000", response); else passed++;
    endtask

    task automatic test_single_write();
        int wc0;
        wc0 = wr_count;
        set_core(2, 1'b1, 32'h20, 32'h12345678);
        step();
        checks++; if (mem_wren !== 1'b1) $display("FAIL write_wren got=%0b exp=1", mem_wren); else passed++;
        checks++; if (mem_address !== 32'h20) $display("FAIL write_addr got=%h exp=20", mem_address); else passed++;
        checks++; if (mem_writedata !== 32'h12345678) $display("FAIL write_data got=%h exp=12345678", mem_writedata); else passed++;
        step();
        checks++; if (mem_wren !== 1'b0) $display("FAIL write_wren_drop got=%0b exp=0", mem_wren); else passed++;
        step();
        step();
        checks++; if (response !== 4'b0100) $display("FAIL write_resp got=%b exp=0100", response); else passed++;
        checks++; if (readdata !== exp_readdata) $display("FAIL write_readdata got=%h exp=%h", readdata, exp_readdata); else passed++;
        checks++; if (wr_count !== wc0 + 1) $display("FAIL write_strobes got=%0d exp=%0d", wr_count - wc0, 1); else passed++;
        model_mem[8'h20] = 32'h12345678;
        step();
        step();
    endtask

    task automatic test_contention();
        logic [CORES-1:0] r;
        int n;
        do_reset();
        for (int i = 0; i < int'(CORES); i++) set_core(i, 1'b0, 32'(8'h50 + i), 32'h0);
        for (int k = 0; k < int'(CORES); k++) begin
            wait_resp(r, n);
            checks++; if (r !== 4'(1 << k)) $display("FAIL contention_order k=%0d got=%b exp=%b", k, r, 4'(1 << k)); else passed++;
            checks++; if (n !== 4) $display("FAIL contention_spacing k=%0d got=%0d exp=4", k, n); else passed++;
            checks++; if (readdata !== model_mem[8'h50 + k]) $display("FAIL contention_data k=%0d got=%h exp=%h", k, readdata, model_mem[8'h50 + k]); else passed++;
        end
        step();
    endtask

    task automatic test_fairness();
        logic [CORES-1:0] r;
        int n;
        set_core(1, 1'b0, 32'h61, 32'h0);
        set_core(3, 1'b0, 32'h63, 32'h0);
        wait_resp(r, n);
        checks++; if (r !== 4'b0010) $display("FAIL fair_first got=%b exp=0010", r); else passed++;
        wait_resp(r, n);
        checks++; if (r !== 4'b1000) $display("FAIL fair_second got=%b exp=1000", r); else passed++;
        checks++; if (n !== 4) $display("FAIL fair_spacing got=%0d exp=4", n); else passed++;
        exp_readdata = model_mem[8'h63];
        step();
    endtask

    task automatic test_latched();
        logic [CORES-1:0] r;
        int n;
        set_core(1, 1'b0, 32'h30, 32'h0);
        step();
        address[1*WIDTH +: WIDTH] = 32'h40;
        checks++; if (mem_address !== 32'h30) $display("FAIL latch_issue got=%h exp=30", mem_address); else passed++;
        step();
        checks++; if (mem_address !== 32'h30) $display("FAIL latch_hold got=%h exp=30", mem_address); else passed++;
        wait_resp(r, n);
        checks++; if (r !== 4'b0010) $display("FAIL latch_resp got=%b exp=0010", r); else passed++;
        checks++; if (readdata !== model_mem[8'h30]) $display("FAIL latch_data got=%h exp=%h", readdata, model_mem[8'h30]); else passed++;
        step();
        checks++; if (mem_address !== 32'h30) $display("FAIL latch_after got=%h exp=30", mem_address); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [CORES-1:0] r;
        int n;
        set_core(2, 1'b0, 32'h70, 32'h0);
        step();
        step();
        reset = 1'b1;
        request = '0;
        #1;
        checks++; if (response !== 4'b0000) $display("FAIL midrst_resp got=%b exp=0000", response); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%0b exp=0", busy); else passed++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        drop_pending = '0;
        exp_readdata = '0;
        r = '0;
        for (int c = 0; c < 6; c++) begin
            step();
            r = r | response;
        end
        checks++; if (r !== 4'b0000) $display("FAIL midrst_noresp got=%b exp=0000", r); else passed++;
        set_core(0, 1'b0, 32'h71, 32'h0);
        set_core(3, 1'b0, 32'h72, 32'h0);
        wait_resp(r, n);
        checks++; if (r !== 4'b0001) $display("FAIL midrst_first got=%b exp=0001", r); else passed++;
        wait_resp(r, n);
        checks++; if (r !== 4'b1000) $display("FAIL midrst_second got=%b exp=1000", r); else passed++;
        step();
    endtask

    task automatic test_random();
        logic [CORES-1:0] pend, r;
        logic [CORES-1:0] is_wr;
        logic [WIDTH-1:0] a [CORES];
        logic [WIDTH-1:0] d [CORES];
        int n, g, last, wc;
        do_reset();
        last = CORES - 1;
        for (int round = 0; round < 25; round++) begin
            pend = 4'($urandom_range(1, 15));
            for (int i = 0; i < int'(CORES); i++) begin
                is_wr[i] = 1'($urandom_range(0, 1));
                a[i] = 32'($urandom_range(0, 255));
                d[i] = $urandom;
                if (pend[i]) set_core(i, is_wr[i], a[i], d[i]);
            end
            while (pend != '0) begin
                g = rr_pick(pend, last);
                wc = wr_count;
                wait_resp(r, n);
                checks++; if (r !== 4'(1 << g)) $display("FAIL rand_grant round=%0d got=%b exp=%b", round, r, 4'(1 << g)); else passed++;
                checks++; if (n !== 4) $display("FAIL rand_latency round=%0d got=%0d exp=4", round, n); else passed++;
                if (is_wr[g]) begin
                    model_mem[a[g][7:0]] = d[g];
                    checks++;
                    if (wr_count !== wc + 1 || wr_addr !== a[g] || wr_data !== d[g])
                        $display("FAIL rand_write round=%0d got cnt=%0d addr=%h data=%h exp cnt=1 addr=%h data=%h",
                                 round, wr_count - wc, wr_addr, wr_data, a[g], d[g]);
                    else passed++;
                    checks++; if (readdata !== exp_readdata) $display("FAIL rand_wr_readdata round=%0d got=%h exp=%h", round, readdata, exp_readdata); else passed++;
                end else begin
                    exp_readdata = model_mem[a[g][7:0]];
                    checks++; if (readdata !== exp_readdata) $display("FAIL rand_read round=%0d got=%h exp=%h", round, readdata, exp_readdata); else passed++;
                    checks++; if (wr_count !== wc) $display("FAIL rand_rd_nowrite round=%0d got=%0d exp=0", round, wr_count - wc); else passed++;
                end
                pend[g] = 1'b0;
                last = g;
                if (n < 0) pend = '0;
            end
            step();
            step();
        end
    endtask

    initial begin
        logic [WIDTH-1:0] v;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            ram[i] = v;
            model_mem[i] = v;
        end
        exp_readdata = '0;
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_fairness();
        test_latched();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
